// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encoding, the default
// busy timeout and a small modulo-increment helper.
package uart_pkg;

  typedef logic [1:0] sch_state_t;

  localparam sch_state_t SCH_IDLE      = 2'd0;
  localparam sch_state_t SCH_START     = 2'd1;
  localparam sch_state_t SCH_WAIT_BUSY = 2'd2;
  localparam sch_state_t SCH_WAIT_DONE = 2'd3;

  localparam int DEFAULT_BUSY_TIMEOUT = 15;

  // Index following idx in a ring of n entries.
  function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: returns the first set bit of req_i when scanning
// from ptr_i upward, wrapping at NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [IDW-1:0]     idx_o,
  output logic               found_o
);

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    int cand;
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// streams, with per-requester burst lock and a busy-rise timeout.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_start,
  input  logic                 uart_tx_busy,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id,
  output logic                 timeout_err
);

  localparam int              CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  sch_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             lock_hold_q, lock_hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;

  logic [IDW-1:0]     pick_idx;
  logic               pick_found;
  logic               lock_ok;
  logic [IDW-1:0]     winner;
  logic               have_winner;
  logic [7:0]         win_byte;
  logic [IDW-1:0]     next_ptr;
  logic [NUM_REQ-1:0] ready_c;
  logic               start_c;
  logic               timeout_c;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // A held lock only wins while its owner still offers a byte.
  assign lock_ok     = lock_hold_q && req_valid[grant_id_q];
  assign winner      = lock_ok ? grant_id_q : pick_idx;
  assign have_winner = lock_ok || pick_found;
  assign next_ptr    = IDW'(next_index(32'(grant_id_q), NUM_REQ));

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        win_byte = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_hold_d = lock_hold_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    grant_id_d  = grant_id_q;
    ready_c     = '0;
    start_c     = 1'b0;
    timeout_c   = 1'b0;

    case (state_q)
      SCH_IDLE: begin
        if (lock_hold_q && !lock_ok) begin
          lock_hold_d = 1'b0;
        end
        if (have_winner) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            ready_c[i] = (winner == IDW'(i));
          end
          tx_data_d  = win_byte;
          grant_id_d = winner;
          state_d    = SCH_START;
        end
      end

      SCH_START: begin
        start_c = 1'b1;
        cnt_d   = '0;
        state_d = SCH_WAIT_BUSY;
      end

      SCH_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = SCH_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // The core never started: drop the byte and move on.
          timeout_c   = 1'b1;
          rr_ptr_d    = next_ptr;
          lock_hold_d = 1'b0;
          state_d     = SCH_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SCH_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          rr_ptr_d    = next_ptr;
          lock_hold_d = req_lock[grant_id_q];
          state_d     = SCH_IDLE;
        end
      end

      default: state_d = SCH_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCH_IDLE;
      rr_ptr_q    <= '0;
      lock_hold_q <= 1'b0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_hold_q <= lock_hold_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      grant_id_q  <= grant_id_d;
    end
  end

  // Strobes are masked while rst is high so none fires on the reset edge.
  assign req_ready     = rst ? '0 : ready_c;
  assign uart_tx_start = start_c && !rst;
  assign timeout_err   = timeout_c && !rst;
  assign uart_tx_data  = tx_data_q;
  assign grant_id      = grant_id_q;
  assign grant_valid   = (state_q != SCH_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: byte-level requester queues, a
// UART core stand-in, and a per-cycle transaction model of the scheduler.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int BT = 15;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_lock;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_start;
  logic           uart_tx_busy;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           timeout_err;

  uart_tx_scheduler #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_lock      (req_lock),
    .req_ready     (req_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Requesters: one byte queue each; a byte leaves its queue when accepted.
  logic [7:0] q [N][$];
  logic [N-1:0] lock_en = '0;

  always begin
    logic [N-1:0] rdy_seen;
    @(negedge clk);
    rdy_seen = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy_seen[i] && q[i].size() > 0) void'(q[i].pop_front());
      req_valid[i]       = (q[i].size() > 0);
      req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
      req_lock[i]        = lock_en[i] && (q[i].size() > 0);
    end
  end

  // UART core stand-in: busy rises the cycle after start and lasts u_hold cycles.
  int   u_hold  = 3;
  logic u_never = 1'b0;

  always begin
    logic st, rs;
    int   ucnt;
    @(negedge clk);
    st = uart_tx_start;
    rs = rst;
    @(posedge clk);
    #1;
    if (rs) ucnt = 0;
    else if (st && !u_never) ucnt = u_hold;
    uart_tx_busy = (ucnt > 0);
    if (ucnt > 0) ucnt--;
  end

  // Transaction model: who should win, and the byte's timeline since acceptance.
  int         m_ptr, m_gid, m_age;
  logic       m_lock, m_busy, m_seen;
  logic [7:0] m_data;
  int         cyc = 0, acc_cyc = 0, start_cyc = 0;
  int         gr_log [16];
  int         gr_n = 0;
  logic [7:0] sd_log [16];
  int         sd_n = 0;
  int         gv_cnt = 0, tout_n = 0, tout_gap = 0;

  function automatic int arbitrate();
    if (m_lock && req_valid[m_gid]) return m_gid;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int         w;
    logic [N-1:0] exp_ready;
    logic       exp_start, exp_tout, done;
    cyc++;
    if (uart_tx_start) begin
      if (sd_n < 16) sd_log[sd_n] = uart_tx_data;
      sd_n++;
      start_cyc = cyc;
    end
    if (timeout_err) begin
      tout_gap = cyc - start_cyc;
      tout_n++;
    end
    if (grant_valid) gv_cnt++;

    if (rst) begin
      check("rst_ready", 32'(req_ready), 0);
      check("rst_start", 32'(uart_tx_start), 0);
      check("rst_timeout", 32'(timeout_err), 0);
      m_ptr = 0; m_gid = 0; m_age = 0; m_lock = 0; m_busy = 0; m_seen = 0; m_data = 0;
    end else begin
      w = -1; exp_ready = '0; exp_start = 0; exp_tout = 0; done = 0;
      if (!m_busy) begin
        w = arbitrate();
        if (w >= 0) exp_ready[w] = 1'b1;
      end else begin
        exp_start = (m_age == 1);
        if (m_age >= 2) begin
          if (m_seen) done = !uart_tx_busy;
          else if (uart_tx_busy) m_seen = 1;
          else if (m_age - 1 == BT) begin
            exp_tout = 1;
            done     = 1;
          end
        end
      end

      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("uart_tx_start", 32'(uart_tx_start), 32'(exp_start));
      check("timeout_err", 32'(timeout_err), 32'(exp_tout));
      check("grant_valid", 32'(grant_valid), 32'(m_busy));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("uart_tx_data", 32'(uart_tx_data), 32'(m_data));

      if (!m_busy) begin
        if (m_lock && !req_valid[m_gid]) m_lock = 0;
        if (w >= 0) begin
          m_busy = 1; m_age = 1; m_seen = 0; m_gid = w;
          m_data = req_data[8*w +: 8];
          acc_cyc = cyc;
          if (gr_n < 16) gr_log[gr_n] = w;
          gr_n++;
        end
      end else if (done) begin
        m_busy = 0;
        m_ptr  = (m_gid + 1) % N;
        m_lock = exp_tout ? 1'b0 : req_lock[m_gid];
      end else begin
        m_age++;
      end
    end
  end

  task automatic clear_logs();
    gr_n = 0; sd_n = 0; gv_cnt = 0; tout_n = 0; tout_gap = 0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    int stable = 0;
    while (stable < 3 && k < 2000) begin
      @(negedge clk);
      k++;
      if (!grant_valid && !uart_tx_busy && q[0].size() == 0 && q[1].size() == 0 &&
          q[2].size() == 0 && q[3].size() == 0) stable++;
      else stable = 0;
    end
    check({name, "_idle_reached"}, 32'(stable >= 3), 1);
  endtask

  task automatic check_grants(input string name, input int n, input int e0, input int e1,
                              input int e2, input int e3, input int e4);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    check({name, "_grant_count"}, gr_n, n);
    for (int i = 0; i < n && i < gr_n; i++)
      check($sformatf("%s_grant%0d", name, i), gr_log[i], e[i]);
  endtask

  task automatic check_bytes(input string name, input int n, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    check({name, "_start_count"}, sd_n, n);
    for (int i = 0; i < n && i < sd_n; i++)
      check($sformatf("%s_byte%0d", name, i), 32'(sd_log[i]), 32'(e[i]));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_lock = '0; uart_tx_busy = 1'b0;

    // Reset state and a single byte from requester 0.
    do_reset(2);
    @(negedge clk);
    check("post_reset_grant_valid", 32'(grant_valid), 0);
    check("post_reset_grant_id", 32'(grant_id), 0);
    check("post_reset_tx_data", 32'(uart_tx_data), 0);
    u_hold = 40;
    clear_logs();
    q[0].push_back(8'h5A);
    wait_idle("single");
    check_grants("single", 1, 0, 0, 0, 0, 0);
    check_bytes("single", 1, 8'h5A, 0, 0, 0, 0);
    check("single_accept_to_start", start_cyc - acc_cyc, 1);
    check("single_grant_valid_cycles", gv_cnt, 42);

    // All four requesters contending, no lock.
    do_reset(1);
    u_hold = 3;
    clear_logs();
    @(negedge clk);
    q[0].push_back(8'h10); q[0].push_back(8'h20);
    q[1].push_back(8'h11); q[2].push_back(8'h12); q[3].push_back(8'h13);
    wait_idle("rr");
    check_grants("rr", 5, 0, 1, 2, 3, 0);
    check_bytes("rr", 5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20);

    // Lock burst from requester 1 with 0 and 2 also waiting.
    do_reset(1);
    @(negedge clk);
    q[0].push_back(8'h55);
    wait_idle("lock_prefix");
    clear_logs();
    @(negedge clk);
    lock_en[1] = 1'b1;
    q[1].push_back(8'hA1); q[1].push_back(8'hA2); q[1].push_back(8'hA3);
    q[0].push_back(8'h01); q[2].push_back(8'h02);
    wait_idle("lock");
    lock_en[1] = 1'b0;
    check_grants("lock", 5, 1, 1, 1, 2, 0);
    check_bytes("lock", 5, 8'hA1, 8'hA2, 8'hA3, 8'h02, 8'h01);

    // Core never raises busy: both bytes time out, service rotates on.
    u_never = 1'b1;
    clear_logs();
    @(negedge clk);
    q[2].push_back(8'h77); q[3].push_back(8'h33);
    wait_idle("timeout");
    u_never = 1'b0;
    check_grants("timeout", 2, 2, 3, 0, 0, 0);
    check_bytes("timeout", 2, 8'h77, 8'h33, 0, 0, 0);
    check("timeout_pulses", tout_n, 2);
    check("timeout_gap", tout_gap, BT);

    // Pointer wrap after granting the last requester.
    do_reset(1);
    u_hold = 2;
    clear_logs();
    @(negedge clk);
    q[1].push_back(8'h1B);
    wait_idle("wrap_a");
    q[3].push_back(8'h3C);
    wait_idle("wrap_b");
    q[0].push_back(8'hC0); q[2].push_back(8'h2C);
    wait_idle("wrap_c");
    check_grants("wrap", 4, 1, 3, 0, 2, 0);
    check_bytes("wrap", 4, 8'h1B, 8'h3C, 8'hC0, 8'h2C, 0);

    // Reset while a byte is in WAIT_DONE.
    do_reset(1);
    u_hold = 40;
    @(negedge clk);
    q[2].push_back(8'h99);
    begin
      int k = 0;
      while (!uart_tx_start && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("midreset_start_seen", 32'(uart_tx_start), 1);
    end
    repeat (10) @(negedge clk);
    q[1].push_back(8'h11); q[3].push_back(8'h33);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_grant_valid", 32'(grant_valid), 0);
    check("midreset_start", 32'(uart_tx_start), 0);
    check("midreset_ready", 32'(req_ready), 0);
    check("midreset_grant_id", 32'(grant_id), 0);
    clear_logs();
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle("midreset");
    check_grants("midreset", 2, 1, 3, 0, 0, 0);
    check_bytes("midreset", 2, 8'h11, 8'h33, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters.
- Arbitration is round-robin, with an optional per-requester lock so a requester can send a multi-byte burst without interleaving.
- Sits between client logic and the UART core's tx_data / tx_start / tx_busy interface.
- Sequences each byte as: handshake start, confirm busy, wait for completion. A busy-timeout recovers from a core that never starts.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 15, cycles allowed after uart_tx_start for uart_tx_busy to rise.
- IDW, $clog2(NUM_REQ), width of the grant index (derived, not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a byte on req_data slice i.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- req_lock  in  NUM_REQ  requester i holds the grant for its next byte.
- req_ready  out  NUM_REQ  one-cycle accept strobe; byte i transfers at the clk edge where valid&ready.
- uart_tx_data  out  8  byte presented to the UART core.
- uart_tx_start  out  1  one-cycle start strobe to the UART core.
- uart_tx_busy  in  1  UART transmitter busy.
- grant_valid  out  1  a byte is in flight (state != IDLE).
- grant_id  out  IDW  index of the current/last granted requester.
- timeout_err  out  1  one-cycle pulse when uart_tx_busy fails to rise.

Behaviour:
- Reset values (sync, rst high at a clk edge):
  - state=IDLE; all outputs 0.
  - rr_ptr=0; lock_hold=0; timeout counter=0.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE arbitration:
  - If lock_hold=1 and req_valid[grant_id]=1, the winner is grant_id.
  - Otherwise the winner is the first set req_valid scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If no req_valid is set, remain in IDLE with req_ready=0.
- IDLE with a winner w:
  - req_ready[w]=1 combinationally in that cycle; all other req_ready bits are 0.
  - At the edge: capture req_data slice w into uart_tx_data, grant_id<=w, go to START.
- START (exactly 1 cycle): uart_tx_start=1, clear the timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - If uart_tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches BUSY_TIMEOUT-1 with busy still 0: pulse timeout_err, advance rr_ptr to w+1 (wrap), clear lock_hold, go to IDLE. The byte is dropped.
- WAIT_DONE: when uart_tx_busy=0, go to IDLE.
  - rr_ptr <= w+1 modulo NUM_REQ (wrap from NUM_REQ-1 to 0).
  - lock_hold <= req_lock[w], sampled in this cycle.
- uart_tx_data holds the captured byte from START until the next capture; it never changes while grant_valid=1.
- grant_valid = (state != IDLE).
- Timing:
  - Minimum byte-to-byte gap is 1 IDLE cycle after busy falls.
  - Latency from valid (in IDLE) to uart_tx_start is 1 cycle.
- Lock while invalid: if lock_hold=1 but the locked requester deasserts valid in IDLE, the lock is released (lock_hold<=0) and normal round-robin applies in that same cycle.
- req_valid dropping after accept has no effect on the byte in flight.
- uart_tx_busy already 1 in IDLE: ignored. Arbitration in IDLE does not wait on busy; the WAIT_BUSY timeout covers a stuck core.
- rst in any state aborts immediately. No req_ready, start or timeout pulse is emitted on the reset edge.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants SCH_IDLE=0, SCH_START=1, SCH_WAIT_BUSY=2, SCH_WAIT_DONE=3.
  - Default BUSY_TIMEOUT constant.
- One sub-module rr_picker (purely combinational).
  - Inputs: req vector and pointer.
  - Outputs: winner index and a found flag.
  - Instantiated once; keeps the rotate/priority logic unit-testable.

Test Plan:
- Single requester: req_valid=4'b0001, data 0x5A, UART model raises busy 1 cycle after start and holds it 40 cycles -> req_ready[0] for 1 cycle; uart_tx_start 1 cycle later with uart_tx_data=0x5A; grant_valid stays high until busy falls.
- All four valid continuously with lock=0, data 0x10..0x13 -> grant order 0,1,2,3,0; each accepted byte matches its slice; never two req_ready bits high.
- Lock burst: req1 valid with lock=1 for 3 bytes (0xA1, 0xA2, 0xA3) while req0 and req2 are also valid -> grants 1,1,1, then 2, then 0.
- Timeout: UART model never asserts busy -> timeout_err pulses exactly BUSY_TIMEOUT cycles after uart_tx_start; state returns to IDLE; next requester is served.
- Pointer wrap: NUM_REQ=4, only req3 then req0 valid -> grant 3, then 0; rr_ptr wraps to 0 after grant 3.
- Reset mid-byte: assert rst during WAIT_DONE -> next cycle grant_valid=0, uart_tx_start=0, req_ready=0, grant_id=0; the first post-reset grant goes to the lowest-index valid requester.
